// File: rtl/br_flow_stabilize_pkg.sv
// Shared constants for the flow stabilizer.
//   ST_PASS : flow forwards push -> pop combinationally
//   ST_HOLD : flow presents its captured beat until it drains
package br_flow_stabilize_pkg;
    localparam logic [0:0] ST_PASS = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
endpackage

// File: rtl/br_flow_stabilize_if.sv
// Multi-flow ready/valid bundle.
//   valid : per-flow valid (master -> slave)
//   data  : per-flow payload (master -> slave)
//   ready : per-flow ready (slave -> master)
interface br_flow_stabilize_if #(
    parameter int NumFlows = 1,
    parameter int Width    = 1
);
    logic [NumFlows-1:0]            valid;
    logic [NumFlows-1:0]            ready;
    logic [NumFlows-1:0][Width-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/br_flow_stabilize_1.sv
// One flow of the stabilizer: PASS/HOLD FSM, one-beat hold register and a
// saturating stall counter.
//   push_valid/push_ready/push_data : loosely behaved upstream side
//   pop_valid/pop_ready/pop_data    : compliant downstream side
//   stall_count                     : backpressured cycles of current pop beat
//   stall_saturated                 : sticky, stall_count hit all-ones
module br_flow_stabilize_1
    import br_flow_stabilize_pkg::*;
#(
    parameter int Width           = 1,
    parameter int StallCountWidth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [Width-1:0]           push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [Width-1:0]           pop_data,
    output logic [StallCountWidth-1:0] stall_count,
    output logic                       stall_saturated
);
    localparam logic [StallCountWidth-1:0] CntMax = '1;

    logic [0:0]       state;
    logic [Width-1:0] hold_q;

    // Ready comes only from the state flop: no ready-to-ready path.
    assign push_ready = (state == ST_PASS);
    // Gating with rst_n makes pop_valid drop the moment reset asserts, even
    // while push_valid is high in PASS.
    assign pop_valid  = rst_n & ((state == ST_HOLD) | push_valid);
    assign pop_data   = (state == ST_HOLD) ? hold_q : push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_PASS;
            hold_q <= '0;
        end else begin
            case (state)
                ST_PASS: if (push_valid && !pop_ready) begin
                    // Beat is accepted upstream but not taken downstream:
                    // freeze it so upstream may retract or change.
                    hold_q <= push_data;
                    state  <= ST_HOLD;
                end
                default: if (pop_ready) state <= ST_PASS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count     <= '0;
            stall_saturated <= 1'b0;
        end else begin
            if (pop_valid && pop_ready)
                stall_count <= '0;
            else if (pop_valid && stall_count != CntMax)
                stall_count <= stall_count + 1'b1;
            if (stall_count == CntMax)
                stall_saturated <= 1'b1;
        end
    end
endmodule

// File: rtl/br_flow_stabilize.sv
// Multi-flow ready/valid stabilizer. Slices the bundles per flow, instantiates
// one br_flow_stabilize_1 per flow and checks pop-side compliance.
//   clk, rst_n      : clock, async active-low reset
//   push            : upstream bundle (slave side)
//   pop             : downstream bundle (master side)
//   stall_count     : per-flow saturating stall counters
//   stall_saturated : per-flow sticky saturation flags
module br_flow_stabilize #(
    parameter int NumFlows        = 1,
    parameter int Width           = 1,
    parameter int StallCountWidth = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    br_flow_stabilize_if.slave                        push,
    br_flow_stabilize_if.master                       pop,
    output logic [NumFlows-1:0][StallCountWidth-1:0]  stall_count,
    output logic [NumFlows-1:0]                       stall_saturated
);
    logic [NumFlows-1:0]            push_ready;
    logic [NumFlows-1:0]            pop_valid;
    logic [NumFlows-1:0][Width-1:0] pop_data;

    assign push.ready = push_ready;
    assign pop.valid  = pop_valid;
    assign pop.data   = pop_data;

    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
        br_flow_stabilize_1 #(
            .Width           (Width),
            .StallCountWidth (StallCountWidth)
        ) u_flow (
            .clk             (clk),
            .rst_n           (rst_n),
            .push_valid      (push.valid[i]),
            .push_ready      (push_ready[i]),
            .push_data       (push.data[i]),
            .pop_valid       (pop_valid[i]),
            .pop_ready       (pop.ready[i]),
            .pop_data        (pop_data[i]),
            .stall_count     (stall_count[i]),
            .stall_saturated (stall_saturated[i])
        );

        // Flow integrity: a backpressured pop beat stays valid and unchanged.
        a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (pop_valid[i] && !pop.ready[i]) |=>
                (pop_valid[i] && pop_data[i] == $past(pop_data[i])));

        a_push_known: assert property (@(posedge clk) disable iff (!rst_n)
            (push.valid[i] && push_ready[i]) |-> !$isunknown(push.data[i]));
    end
endmodule

// File: tb/tb_br_flow_stabilize.sv
module tb_br_flow_stabilize;
    localparam int NF = 2;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NF-1:0][SW-1:0] stall_count;
    logic [NF-1:0]         stall_saturated;

    br_flow_stabilize_if #(.NumFlows(NF), .Width(W)) push_if ();
    br_flow_stabilize_if #(.NumFlows(NF), .Width(W)) pop_if ();

    br_flow_stabilize #(.NumFlows(NF), .Width(W), .StallCountWidth(SW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .push            (push_if.slave),
        .pop             (pop_if.master),
        .stall_count     (stall_count),
        .stall_saturated (stall_saturated)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] sb [NF][$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        push_if.valid = '0;
        push_if.data  = '0;
        pop_if.ready  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int f = 0; f < NF; f++) sb[f].delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        push_if.valid = '1;
        push_if.data  = {8'h77, 8'h66};
        pop_if.ready  = '1;
        #2;
        vectors++;
        if (pop_if.valid !== 2'b00) begin miscompares++; $display("FAIL reset_pop_valid got %b exp 00", pop_if.valid); end
        vectors++;
        if (push_if.ready !== 2'b11) begin miscompares++; $display("FAIL reset_push_ready got %b exp 11", push_if.ready); end
        vectors++;
        if (stall_count !== '0 || stall_saturated !== 2'b00) begin miscompares++; $display("FAIL reset_counters got %h/%b exp 0/00", stall_count, stall_saturated); end
        apply_reset();
    endtask

    task automatic test_pass_through;
        logic [W-1:0] d;
        apply_reset();
        pop_if.ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            d = 8'h10 + 8'(i);
            push_if.valid[0] = 1'b1;
            push_if.data[0]  = d;
            #2;
            vectors++;
            if (pop_if.valid[0] !== 1'b1 || pop_if.data[0] !== d) begin miscompares++; $display("FAIL pass_data[%0d] got v=%b d=%h exp v=1 d=%h", i, pop_if.valid[0], pop_if.data[0], d); end
            vectors++;
            if (push_if.ready[0] !== 1'b1 || stall_count[0] !== 2'd0) begin miscompares++; $display("FAIL pass_ready_stall[%0d] got r=%b s=%0d exp r=1 s=0", i, push_if.ready[0], stall_count[0]); end
            tick();
        end
        push_if.valid = '0;
    endtask

    task automatic test_retraction;
        logic [SW-1:0] exp_s [5];
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_if.valid[0] = (i == 0);
            push_if.data[0]  = (i == 0) ? 8'hA5 : 8'h3C;
            pop_if.ready[0]  = (i >= 3);
            #2;
            if (i < 4) begin
                vectors++;
                if (pop_if.valid[0] !== 1'b1 || pop_if.data[0] !== 8'hA5) begin miscompares++; $display("FAIL retract_hold[%0d] got v=%b d=%h exp v=1 d=a5", i, pop_if.valid[0], pop_if.data[0]); end
            end else begin
                vectors++;
                if (pop_if.valid[0] !== 1'b0) begin miscompares++; $display("FAIL retract_drained got v=%b exp 0", pop_if.valid[0]); end
            end
            vectors++;
            if (push_if.ready[0] !== (i == 0 || i == 4)) begin miscompares++; $display("FAIL retract_ready[%0d] got %b exp %b", i, push_if.ready[0], (i == 0 || i == 4)); end
            vectors++;
            if (stall_count[0] !== exp_s[i]) begin miscompares++; $display("FAIL retract_stall[%0d] got %0d exp %0d", i, stall_count[0], exp_s[i]); end
            tick();
        end
    endtask

    task automatic test_saturation;
        logic [SW-1:0] exp_s [8];
        logic          exp_sat [8];
        exp_s   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        exp_sat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            push_if.valid[0] = (i == 0);
            push_if.data[0]  = 8'h55;
            pop_if.ready[0]  = (i >= 6);
            #2;
            vectors++;
            if (stall_count[0] !== exp_s[i]) begin miscompares++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, stall_count[0], exp_s[i]); end
            vectors++;
            if (stall_saturated[0] !== exp_sat[i]) begin miscompares++; $display("FAIL sat_flag[%0d] got %b exp %b", i, stall_saturated[0], exp_sat[i]); end
            if (i == 6) begin
                vectors++;
                if (pop_if.valid[0] !== 1'b1 || pop_if.data[0] !== 8'h55) begin miscompares++; $display("FAIL sat_drain got v=%b d=%h exp v=1 d=55", pop_if.valid[0], pop_if.data[0]); end
            end
            tick();
        end
    endtask

    task automatic test_bubble;
        logic         pr [5];
        int           bubbles = 0;
        int           pops = 0;
        logic [W-1:0] e;
        pr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            push_if.valid[0] = (i < 5);
            push_if.data[0]  = 8'h20 + 8'(i);
            pop_if.ready[0]  = (i < 5) ? pr[i] : 1'b1;
            #2;
            if (push_if.ready[0] === 1'b0) bubbles++;
            if (push_if.valid[0] && push_if.ready[0]) sb[0].push_back(push_if.data[0]);
            if (pop_if.valid[0] && pop_if.ready[0]) begin
                pops++;
                vectors++;
                if (sb[0].size() == 0) begin miscompares++; $display("FAIL bubble_extra_pop got %h exp none", pop_if.data[0]); end
                else begin
                    e = sb[0].pop_front();
                    if (pop_if.data[0] !== e) begin miscompares++; $display("FAIL bubble_data got %h exp %h", pop_if.data[0], e); end
                end
            end
            tick();
        end
        push_if.valid = '0;
        vectors++;
        if (bubbles != 1) begin miscompares++; $display("FAIL bubble_count got %0d exp 1", bubbles); end
        vectors++;
        if (pops != 4 || sb[0].size() != 0) begin miscompares++; $display("FAIL bubble_pops got %0d left %0d exp 4 left 0", pops, sb[0].size()); end
    endtask

    task automatic test_independence;
        int           pops [NF];
        logic [W-1:0] e;
        pops = '{0, 0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            push_if.valid[0] = (i == 0);
            push_if.data[0]  = (i == 0) ? 8'hE7 : 8'h5A + 8'(i);
            push_if.valid[1] = (i < 4);
            push_if.data[1]  = 8'h01 + 8'(i);
            pop_if.ready     = {1'b1, (i == 4)};
            #2;
            vectors++;
            if (pop_if.valid[0] !== 1'b1 || pop_if.data[0] !== 8'hE7) begin miscompares++; $display("FAIL indep_hold[%0d] got v=%b d=%h exp v=1 d=e7", i, pop_if.valid[0], pop_if.data[0]); end
            if (i < 4) begin
                vectors++;
                if (push_if.ready[1] !== 1'b1 || pop_if.valid[1] !== 1'b1) begin miscompares++; $display("FAIL indep_f1_flow[%0d] got r=%b v=%b exp 1/1", i, push_if.ready[1], pop_if.valid[1]); end
            end
            for (int f = 0; f < NF; f++) begin
                if (push_if.valid[f] && push_if.ready[f]) sb[f].push_back(push_if.data[f]);
                if (pop_if.valid[f] && pop_if.ready[f]) begin
                    pops[f]++;
                    vectors++;
                    if (sb[f].size() == 0) begin miscompares++; $display("FAIL indep_extra_pop f%0d got %h exp none", f, pop_if.data[f]); end
                    else begin
                        e = sb[f].pop_front();
                        if (pop_if.data[f] !== e) begin miscompares++; $display("FAIL indep_data f%0d got %h exp %h", f, pop_if.data[f], e); end
                    end
                end
            end
            tick();
        end
        push_if.valid = '0;
        vectors++;
        if (pops[0] != 1 || pops[1] != 4 || sb[0].size() != 0 || sb[1].size() != 0) begin miscompares++; $display("FAIL indep_totals got %0d/%0d exp 1/4", pops[0], pops[1]); end
    endtask

    task automatic test_async_reset;
        apply_reset();
        push_if.valid[0] = 1'b1;
        push_if.data[0]  = 8'h99;
        pop_if.ready[0]  = 1'b0;
        tick();
        push_if.valid[0] = 1'b0;
        tick();
        #2;
        vectors++;
        if (pop_if.valid[0] !== 1'b1 || stall_count[0] !== 2'd2) begin miscompares++; $display("FAIL arst_pre got v=%b s=%0d exp v=1 s=2", pop_if.valid[0], stall_count[0]); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (pop_if.valid[0] !== 1'b0 || push_if.ready[0] !== 1'b1) begin miscompares++; $display("FAIL arst_now got v=%b r=%b exp v=0 r=1", pop_if.valid[0], push_if.ready[0]); end
        vectors++;
        if (stall_count[0] !== 2'd0) begin miscompares++; $display("FAIL arst_count got %0d exp 0", stall_count[0]); end
        tick();
        rst_n = 1'b1;
        push_if.valid[0] = 1'b1;
        push_if.data[0]  = 8'h42;
        pop_if.ready[0]  = 1'b1;
        #2;
        vectors++;
        if (pop_if.valid[0] !== 1'b1 || pop_if.data[0] !== 8'h42) begin miscompares++; $display("FAIL arst_after got v=%b d=%h exp v=1 d=42", pop_if.valid[0], pop_if.data[0]); end
        tick();
        push_if.valid = '0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_retraction();
        test_saturation();
        test_bubble();
        test_independence();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/br_flow_stabilize.md
Name: br_flow_stabilize

Overview:
- Per-flow hold stage that converts a loosely behaved ready-valid source into a strictly compliant ready-valid output.
- Upstream (push) may retract valid or change data at any time; downstream (pop) sees valid/data held stable under backpressure.
- Sits directly upstream of the flow integrity checks on arbiter, mux and demux outputs, so downstream stability assertions hold.
- Also reports per-flow stall length for debug.

Parameters:
- NumFlows, 1, number of independent flows; must be >= 1.
- Width, 1, data width per flow; must be >= 1.
- StallCountWidth, 8, width of each per-flow stall counter; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- push_valid  input  NumFlows  upstream valid; may drop without acceptance.
- push_ready  output  NumFlows  upstream ready; registered (state-derived only).
- push_data  input  NumFlows x Width  upstream data; may change while unaccepted.
- pop_valid  output  NumFlows  downstream valid; compliant.
- pop_ready  input  NumFlows  downstream ready.
- pop_data  output  NumFlows x Width  downstream data; stable while pop_valid && !pop_ready.
- stall_count  output  NumFlows x StallCountWidth  consecutive backpressured cycles of the current pop beat; saturating.
- stall_saturated  output  NumFlows  sticky; set when any stall_count of that flow reached all-ones.

Behaviour:
- Each flow is independent, with a two-state FSM: PASS and HOLD.
- Reset (rst_n low, async): state=PASS, hold register=0, stall_count=0, stall_saturated=0, push_ready=1, pop_valid=0 (push_valid is ignored while in reset).
- PASS state:
  - pop_valid=push_valid, pop_data=push_data; 0-cycle combinational forward path.
  - push_ready=1.
  - push_valid && pop_ready: beat transfers this cycle; stay in PASS.
  - push_valid && !pop_ready: capture push_data into the hold register; next state HOLD. The push beat counts as accepted.
  - !push_valid: stay in PASS.
- HOLD state:
  - pop_valid=1, pop_data=hold register; push_ready=0; push_valid/push_data are ignored.
  - pop_ready: next state PASS.
  - !pop_ready: stay in HOLD, hold register unchanged.
- Consequence: at most one beat is stored per flow. After a HOLD drains, the next push is accepted one cycle later at the earliest, i.e. one bubble per backpressure event. In the unstalled case throughput is 1 beat/cycle.
- No ready-to-ready combinational path. The valid/data combinational path exists only in PASS.
- stall_count:
  - Increments on each cycle with pop_valid && !pop_ready.
  - Clears to 0 on the cycle after pop_valid && pop_ready.
  - Holds at all-ones (saturates) and never wraps.
  - Holds its value while pop_valid=0.
- stall_saturated: set the cycle after stall_count reaches all-ones; cleared only by reset.
- Simultaneous events: push and pop on the same cycle in PASS is a pure pass-through with no state change. HOLD→PASS and a new push cannot both occur on the same cycle, because push_ready=0 in HOLD.
- Reset mid-HOLD: the held beat is discarded, the flow returns to PASS, and pop_valid drops asynchronously.
- Integration: instantiates the flow integrity checks on the pop side with stability assertions enabled. Asserts push_data known when push_valid && push_ready.
- End of test: the final-not-valid check applies to pop_valid only.

Decomposition:
- No package needed.
- The FSM encoding is a local enum { PASS, HOLD }.
- Natural sub-module: br_flow_stabilize_1, one flow (FSM, hold register, stall counter), instantiated NumFlows times via generate. The top level only slices buses and instantiates the checker.

Test Plan:
- Pass-through: Width=8, pop_ready=1, push_valid=1, push_data 0x10,0x11,0x12 on consecutive cycles -> pop_data 0x10,0x11,0x12 same cycles; push_ready stays 1; stall_count=0.
- Retraction under stall: push 0xA5 with pop_ready=0; next cycle push_valid=0, push_data=0x3C -> pop_valid=1, pop_data=0xA5 held; push_ready=0. Raise pop_ready after 3 stall cycles -> 0xA5 transfers; stall_count reads 3 before clearing.
- Bubble after drain: continuous push; pop_ready pattern 0,1,1 -> exactly one push_ready=0 cycle; no beat lost or duplicated, checked with a scoreboard.
- Saturation: StallCountWidth=2, pop_ready=0 for 6 cycles -> stall_count 1,2,3,3,3; stall_saturated=1 and remains 1 after drain.
- Independence: NumFlows=2, flow 0 stalled in HOLD while flow 1 streams 0x01..0x04 -> flow 1 is unaffected; flow 0 releases its held beat intact.
- Async reset in HOLD: assert rst_n=0 mid-cycle -> pop_valid=0 immediately, push_ready=1, counters 0; after release, the first push passes through combinationally.
